hazard_ctrl: RTL and testbench

- Hazard and stall controller that consumes the ID/EX pipeline register outputs (O_MemRead, O_RegWrite, O_writeRegister) together with ID-stage register addresses, EX branch resolution and the data-memory/multi-cycle-EX handshakes.
- Drives write-enables and flushes back into the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Keeps saturating performance counters and a freeze watchdog.

---
 rtl/hazard_ctrl.sv | 158 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard and stall controller for a five-stage core.
//
// Looks at the ID/EX register outputs (MemRead, RegWrite, rd), the register
// addresses read by the instruction in ID, EX branch resolution and the
// data-memory / multi-cycle-EX handshakes. It then drives write enables and
// bubble flushes into the pipeline registers. Priority: freeze > branch >
// load-use > normal. Saturating performance counters and a sticky freeze
// watchdog are kept alongside.
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   I_ID_readRegister1/2      rs1/rs2 of the instruction in ID
//   I_ID_useRs1/2             ID instruction actually reads rs1/rs2
//   I_EX_MemRead/RegWrite     ID/EX control outputs
//   I_EX_writeRegister        ID/EX rd
//   I_EX_branchTaken          taken branch/jump resolved in EX
//   I_EX_multiBusy            multi-cycle EX op still running
//   I_MEM_access/I_MEM_ready  data-memory access and completion handshake
//   I_clearCounters           synchronous clear of the performance counters
//   O_*Write                  pipeline register write enables
//   O_IFIDFlush/O_IDEXFlush   bubble insertion into IF/ID and ID/EX
//   O_stallCount/O_flushCount/O_freezeCount  saturating event counters
//   O_timeout                 sticky watchdog flag
module hazard_ctrl #(
  parameter int COUNT_WIDTH = 16,
  parameter int WAIT_LIMIT  = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [4:0]             I_ID_readRegister1,
  input  logic [4:0]             I_ID_readRegister2,
  input  logic                   I_ID_useRs1,
  input  logic                   I_ID_useRs2,
  input  logic                   I_EX_MemRead,
  input  logic                   I_EX_RegWrite,
  input  logic [4:0]             I_EX_writeRegister,
  input  logic                   I_EX_branchTaken,
  input  logic                   I_EX_multiBusy,
  input  logic                   I_MEM_access,
  input  logic                   I_MEM_ready,
  input  logic                   I_clearCounters,
  output logic                   O_PCWrite,
  output logic                   O_IFIDWrite,
  output logic                   O_IDEXWrite,
  output logic                   O_EXMEMWrite,
  output logic                   O_MEMWBWrite,
  output logic                   O_IFIDFlush,
  output logic                   O_IDEXFlush,
  output logic [COUNT_WIDTH-1:0] O_stallCount,
  output logic [COUNT_WIDTH-1:0] O_flushCount,
  output logic [COUNT_WIDTH-1:0] O_freezeCount,
  output logic                   O_timeout
);

  // A zero-width counter is illegal, so the disabled watchdog keeps one bit.
  localparam int WAIT_W = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;
  localparam logic [WAIT_W-1:0]      WAIT_MAX = WAIT_W'(WAIT_LIMIT);
  localparam logic [WAIT_W-1:0]      WAIT_ONE = WAIT_W'(1);
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE  = COUNT_WIDTH'(1);

  typedef enum logic {RUN = 1'b0, FREEZE = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [WAIT_W-1:0]      wait_q, wait_d;
  logic                   timeout_q, timeout_d;
  logic [COUNT_WIDTH-1:0] stall_q, stall_d;
  logic [COUNT_WIDTH-1:0] flush_q, flush_d;
  logic [COUNT_WIDTH-1:0] freeze_cnt_q, freeze_cnt_d;

  logic freeze, rs1_hit, rs2_hit, load_use, branch_ev, load_use_ev;

  function automatic logic [COUNT_WIDTH-1:0] sat_inc(
    input logic [COUNT_WIDTH-1:0] v,
    input logic                   en
  );
    return (en && (v != '1)) ? v + CNT_ONE : v;
  endfunction

  always_comb begin
    freeze  = (I_MEM_access & ~I_MEM_ready) | I_EX_multiBusy;
    rs1_hit = I_ID_useRs1 & (I_ID_readRegister1 == I_EX_writeRegister);
    rs2_hit = I_ID_useRs2 & (I_ID_readRegister2 == I_EX_writeRegister);
    // x0 is hardwired zero, so a load into it never creates a dependency.
    load_use = I_EX_MemRead & I_EX_RegWrite & (I_EX_writeRegister != 5'd0)
             & (rs1_hit | rs2_hit);
    // A branch seen during a freeze stays asserted while EX is held, so
    // only the first unfrozen cycle counts as the flush event.
    branch_ev   = ~freeze & I_EX_branchTaken;
    load_use_ev = ~freeze & ~I_EX_branchTaken & load_use;
  end

  always_comb begin
    O_PCWrite    = 1'b0;
    O_IFIDWrite  = 1'b0;
    O_IDEXWrite  = 1'b0;
    O_EXMEMWrite = 1'b0;
    O_MEMWBWrite = 1'b0;
    O_IFIDFlush  = 1'b0;
    O_IDEXFlush  = 1'b0;
    if (rst && !freeze) begin
      O_PCWrite    = 1'b1;
      O_IFIDWrite  = 1'b1;
      O_IDEXWrite  = 1'b1;
      O_EXMEMWrite = 1'b1;
      O_MEMWBWrite = 1'b1;
      if (I_EX_branchTaken) begin
        O_IFIDFlush = 1'b1;
        O_IDEXFlush = 1'b1;
      end else if (load_use) begin
        // Hold PC and IF/ID, push one bubble into ID/EX.
        O_PCWrite   = 1'b0;
        O_IFIDWrite = 1'b0;
        O_IDEXFlush = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = freeze ? FREEZE : RUN;

    // The FSM state tells whether this freeze cycle starts a new run.
    wait_d = '0;
    if (freeze && (WAIT_LIMIT > 0)) begin
      if (state_q == RUN)         wait_d = WAIT_ONE;
      else if (wait_q != WAIT_MAX) wait_d = wait_q + WAIT_ONE;
      else                         wait_d = wait_q;
    end
    timeout_d = timeout_q | ((WAIT_LIMIT > 0) && (wait_d == WAIT_MAX));

    stall_d      = I_clearCounters ? '0 : sat_inc(stall_q, load_use_ev);
    flush_d      = I_clearCounters ? '0 : sat_inc(flush_q, branch_ev);
    freeze_cnt_d = I_clearCounters ? '0 : sat_inc(freeze_cnt_q, freeze);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= RUN;
      wait_q       <= '0;
      timeout_q    <= 1'b0;
      stall_q      <= '0;
      flush_q      <= '0;
      freeze_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      timeout_q    <= timeout_d;
      stall_q      <= stall_d;
      flush_q      <= flush_d;
      freeze_cnt_q <= freeze_cnt_d;
    end
  end

  assign O_stallCount  = stall_q;
  assign O_flushCount  = flush_q;
  assign O_freezeCount = freeze_cnt_q;
  assign O_timeout     = timeout_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl with COUNT_WIDTH = 2 and WAIT_LIMIT = 4.
module tb_hazard_ctrl;
  localparam int CW   = 2;
  localparam int WL   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] rs1, rs2, rd;
  logic use1, use2, memrd, regwr, br, busy, acc, rdy, clr;
  logic pcw, ifidw, idexw, exmemw, memwbw, ifidf, idexf, tmo;
  logic [CW-1:0] stall_c, flush_c, freeze_c;
  logic [6:0] ctrl;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state
  int m_stall, m_flush, m_freeze, m_run;
  bit m_to;

  always #5 clk = ~clk;

  assign ctrl = {pcw, ifidw, idexw, exmemw, memwbw, ifidf, idexf};

  hazard_ctrl #(.COUNT_WIDTH(CW), .WAIT_LIMIT(WL)) dut (
    .clk(clk), .rst(rst),
    .I_ID_readRegister1(rs1), .I_ID_readRegister2(rs2),
    .I_ID_useRs1(use1), .I_ID_useRs2(use2),
    .I_EX_MemRead(memrd), .I_EX_RegWrite(regwr), .I_EX_writeRegister(rd),
    .I_EX_branchTaken(br), .I_EX_multiBusy(busy),
    .I_MEM_access(acc), .I_MEM_ready(rdy), .I_clearCounters(clr),
    .O_PCWrite(pcw), .O_IFIDWrite(ifidw), .O_IDEXWrite(idexw),
    .O_EXMEMWrite(exmemw), .O_MEMWBWrite(memwbw),
    .O_IFIDFlush(ifidf), .O_IDEXFlush(idexf),
    .O_stallCount(stall_c), .O_flushCount(flush_c), .O_freezeCount(freeze_c),
    .O_timeout(tmo)
  );

  function automatic bit m_fz();
    return (acc && !rdy) || busy;
  endfunction

  function automatic bit m_lu();
    bit hit;
    hit = (use1 && rs1 == rd) || (use2 && rs2 == rd);
    return memrd && regwr && (rd != 0) && hit;
  endfunction

  // Expected {PCW,IFIDW,IDEXW,EXMEMW,MEMWBW,IFIDF,IDEXF}
  function automatic logic [6:0] model_ctrl();
    if (!rst)     return 7'b0000000;
    if (m_fz())   return 7'b0000000;
    if (br)       return 7'b1111111;
    if (m_lu())   return 7'b0011101;
    return 7'b1111100;
  endfunction

  task automatic model_reset();
    m_stall = 0; m_flush = 0; m_freeze = 0; m_run = 0; m_to = 0;
  endtask

  task automatic model_edge();
    bit fz, bev, lev;
    if (!rst) begin
      model_reset();
    end else begin
      fz  = m_fz();
      bev = !fz && br;
      lev = !fz && !br && m_lu();
      m_run = fz ? ((m_run < WL) ? m_run + 1 : WL) : 0;
      if (m_run == WL) m_to = 1;
      if (clr) begin
        m_stall = 0; m_flush = 0; m_freeze = 0;
      end else begin
        if (lev && m_stall  < CMAX) m_stall++;
        if (bev && m_flush  < CMAX) m_flush++;
        if (fz  && m_freeze < CMAX) m_freeze++;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    rs1 = 0; rs2 = 0; rd = 0; use1 = 0; use2 = 0; memrd = 0; regwr = 0;
    br = 0; busy = 0; acc = 0; rdy = 0; clr = 0;
  endtask

  task automatic clear_counters();
    idle(); clr = 1; tick(); clr = 0;
  endtask

  task automatic test_reset();
    idle(); rst = 0; br = 1; memrd = 1; regwr = 1; rd = 3; use1 = 1; rs1 = 3;
    model_reset();
    #1;
    n_chk++; if (ctrl !== 7'b0) $display("FAIL reset_ctrl: got %b want 0000000", ctrl); else n_pass++;
    tick(); tick();
    n_chk++; if (ctrl !== 7'b0) $display("FAIL reset_ctrl_held: got %b want 0000000", ctrl); else n_pass++;
    n_chk++; if ({stall_c, flush_c, freeze_c, tmo} !== '0)
      $display("FAIL reset_state: got %0d/%0d/%0d/%0d want 0/0/0/0", stall_c, flush_c, freeze_c, tmo);
    else n_pass++;
    idle(); rst = 1; #1;
    n_chk++; if (ctrl !== 7'b1111100) $display("FAIL reset_release: got %b want 1111100", ctrl); else n_pass++;
    tick();
  endtask

  task automatic test_load_use();
    clear_counters();
    memrd = 1; regwr = 1; rd = 5; use2 = 1; rs2 = 5; rs1 = 7; use1 = 1; #1;
    n_chk++; if (ctrl !== 7'b0011101) $display("FAIL load_use_bubble: got %b want 0011101", ctrl); else n_pass++;
    tick();
    // Bubble now in EX.
    memrd = 0; regwr = 0; rd = 0; #1;
    n_chk++; if (ctrl !== 7'b1111100) $display("FAIL load_use_after: got %b want 1111100", ctrl); else n_pass++;
    tick();
    n_chk++; if (stall_c !== 2'd1) $display("FAIL load_use_count: got %0d want 1", stall_c); else n_pass++;
  endtask

  task automatic test_no_stall();
    clear_counters();
    memrd = 1; regwr = 1; rd = 0; use2 = 1; rs2 = 0; use1 = 1; rs1 = 0; #1;
    n_chk++; if (ctrl !== 7'b1111100) $display("FAIL no_stall_x0: got %b want 1111100", ctrl); else n_pass++;
    tick();
    rd = 5; rs2 = 5; use2 = 0; rs1 = 6; #1;
    n_chk++; if (ctrl !== 7'b1111100) $display("FAIL no_stall_unused: got %b want 1111100", ctrl); else n_pass++;
    tick();
    n_chk++; if (stall_c !== 2'd0) $display("FAIL no_stall_count: got %0d want 0", stall_c); else n_pass++;
    idle();
  endtask

  task automatic test_branch_over_load_use();
    clear_counters();
    memrd = 1; regwr = 1; rd = 9; use1 = 1; rs1 = 9; br = 1; #1;
    n_chk++; if (ctrl !== 7'b1111111) $display("FAIL branch_prio: got %b want 1111111", ctrl); else n_pass++;
    tick(); idle(); tick();
    n_chk++; if (flush_c !== 2'd1 || stall_c !== 2'd0)
      $display("FAIL branch_prio_counts: got flush %0d stall %0d want 1 0", flush_c, stall_c);
    else n_pass++;
  endtask

  task automatic test_freeze_branch();
    clear_counters();
    acc = 1; rdy = 0; br = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_chk++; if (ctrl !== 7'b0) $display("FAIL freeze_hold%0d: got %b want 0000000", i, ctrl); else n_pass++;
      tick();
    end
    rdy = 1; #1;
    n_chk++; if (ctrl !== 7'b1111111) $display("FAIL freeze_release_flush: got %b want 1111111", ctrl); else n_pass++;
    tick(); idle(); tick();
    n_chk++; if (freeze_c !== 2'd3 || flush_c !== 2'd1)
      $display("FAIL freeze_counts: got freeze %0d flush %0d want 3 1", freeze_c, flush_c);
    else n_pass++;
    n_chk++; if (tmo !== 1'b0) $display("FAIL freeze_no_timeout: got %0d want 0", tmo); else n_pass++;
  endtask

  task automatic test_watchdog();
    idle(); busy = 1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      n_chk++; if (tmo !== (k >= WL)) $display("FAIL watchdog_k%0d: got %0d want %0d", k, tmo, (k >= WL)); else n_pass++;
    end
    n_chk++; if (freeze_c !== 2'd3) $display("FAIL freeze_sat: got %0d want 3", freeze_c); else n_pass++;
    busy = 0; #1;
    n_chk++; if (ctrl !== 7'b1111100) $display("FAIL timeout_no_ctrl_effect: got %b want 1111100", ctrl); else n_pass++;
    tick(); tick();
    n_chk++; if (tmo !== 1'b1) $display("FAIL timeout_sticky: got %0d want 1", tmo); else n_pass++;
    // Async reset in the middle of a freeze.
    busy = 1; tick(); #2;
    rst = 0; model_reset(); #1;
    n_chk++; if ({tmo, freeze_c} !== 3'b0) $display("FAIL async_reset: got tmo %0d freeze %0d want 0 0", tmo, freeze_c); else n_pass++;
    n_chk++; if (ctrl !== 7'b0) $display("FAIL async_reset_ctrl: got %b want 0000000", ctrl); else n_pass++;
    idle(); #1; rst = 1; tick();
  endtask

  task automatic test_saturation();
    clear_counters();
    br = 1;
    for (int i = 0; i < 5; i++) tick();
    n_chk++; if (flush_c !== 2'd3) $display("FAIL flush_sat: got %0d want 3", flush_c); else n_pass++;
    clr = 1; tick(); clr = 0; br = 0;
    n_chk++; if (flush_c !== 2'd0) $display("FAIL clear_override: got %0d want 0", flush_c); else n_pass++;
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rs1 = 5'($urandom_range(0, 3)); rs2 = 5'($urandom_range(0, 3)); rd = 5'($urandom_range(0, 3));
      use1 = 1'($urandom); use2 = 1'($urandom);
      memrd = 1'($urandom); regwr = ($urandom_range(0, 3) != 0);
      br = ($urandom_range(0, 3) == 0); busy = ($urandom_range(0, 7) == 0);
      acc = 1'($urandom); rdy = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 31) == 0);
      #1;
      n_chk++; if (ctrl !== model_ctrl()) $display("FAIL rand_ctrl@%0d: got %b want %b", i, ctrl, model_ctrl()); else n_pass++;
      tick();
      n_chk++;
      if (stall_c !== CW'(m_stall) || flush_c !== CW'(m_flush) || freeze_c !== CW'(m_freeze) || tmo !== m_to)
        $display("FAIL rand_state@%0d: got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
                 i, stall_c, flush_c, freeze_c, tmo, m_stall, m_flush, m_freeze, m_to);
      else n_pass++;
    end
    idle();
  endtask

  initial begin
    idle(); rst = 0; model_reset();
    test_reset();
    test_load_use();
    test_no_stall();
    test_branch_over_load_use();
    test_freeze_branch();
    test_watchdog();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
